// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counter / interval timer.
// Contents: FSM state encoding, default counter width, reset values.
// Imported by down_counter_timer.
package down_counter_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reset values (count and reload are zero at any width)
  localparam int unsigned RST_COUNT  = 0;
  localparam int unsigned RST_RELOAD = 0;
  localparam logic        RST_TC     = 1'b0;
  localparam state_e      RST_STATE  = IDLE;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with one-cycle terminal-count pulse.
// Latency: TC reached N enabled cycles after loading N; outputs registered.
// No backpressure: enable simply stalls the count; load overrides any state.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset (beats load and enable)
//   load       - capture load_value this cycle (beats enable)
//   load_value - start value; 0 parks the block in IDLE
//   enable     - decrement qualifier while running
//   count_out  - current count (registered)
//   zero       - count_out == 0 (combinational from count_out)
//   tc_pulse   - one-cycle terminal-count strobe (registered)
//   busy       - high while the FSM is in RUN
//
// Optional build macro DOWN_COUNTER_AUTO_RELOAD_EN: on terminal count the
// counter reloads the last loaded value and keeps running, producing a
// periodic tick. Undefined (default): one-shot, halts in DONE at 0.
import down_counter_timer_pkg::*;

module down_counter_timer #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count_out,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q,    tc_d;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state / next-count logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (load) begin
      // No decrement in the load cycle; a load of 0 has nothing to time.
      count_d = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
      state_d = (load_value != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              // RUN with a zero count cannot be entered; park without a pulse.
              state_d = DONE;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      count_q <= WIDTH'(RST_COUNT);
      tc_q    <= RST_TC;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= WIDTH'(RST_RELOAD);
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count_out = count_q;
  assign zero      = (count_q == '0);
  assign tc_pulse  = tc_q;
  assign busy      = (state_q == RUN);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: the driver pushes hand-computed
// expected outputs tagged with the clock edge they apply to; an independent
// monitor pops and compares them on the falling edge after that edge.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset, load, enable;
  logic [3:0] load_value;
  logic [3:0] count_out;
  logic       zero, tc_pulse, busy;

  typedef struct {
    int         cyc;
    int         idx;
    logic [3:0] count;
    logic       zero;
    logic       tc;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   vec_idx    = 0;
  int   applied    = 0;
  int   miscompare = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .count_out  (count_out),
    .zero       (zero),
    .tc_pulse   (tc_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose edge has just passed.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      applied++;
      if (e.cyc != cyc || count_out !== e.count || zero !== e.zero ||
          tc_pulse !== e.tc || busy !== e.busy) begin
        miscompare++;
        $display("FAIL vec%0d (edge %0d): got count=%0d zero=%0b tc=%0b busy=%0b, expected count=%0d zero=%0b tc=%0b busy=%0b",
                 e.idx, cyc, count_out, zero, tc_pulse, busy, e.count, e.zero, e.tc, e.busy);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic ld, input logic [3:0] lv,
                      input logic en, input logic [3:0] ec, input logic etc,
                      input logic eb);
    exp_t e;
    reset = r; load = ld; load_value = lv; enable = en;
    e.cyc   = cyc + 1;
    e.idx   = vec_idx;
    e.count = ec;
    e.zero  = (ec == 4'd0);
    e.tc    = etc;
    e.busy  = eb;
    exp_q.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load = 1'b0; load_value = 4'd0; enable = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over load
    step(1, 1, 4'd7, 1, 4'd0, 0, 0);
    step(1, 1, 4'd7, 1, 4'd0, 0, 0);

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    // Load 5, continuous enable: 5,4,3,2,1,0 with pulse at 0
    step(0, 1, 4'd5, 0, 4'd5, 0, 1);
    step(0, 0, 4'd0, 1, 4'd4, 0, 1);
    step(0, 0, 4'd0, 1, 4'd3, 0, 1);
    step(0, 0, 4'd0, 1, 4'd2, 0, 1);
    step(0, 0, 4'd0, 1, 4'd1, 0, 1);
    step(0, 0, 4'd0, 1, 4'd0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 4'd0, 1, 4'd0, 0, 0);

    // Load 3, enable 1,0,1,0,1: 3,2,2,1,1,0
    step(0, 1, 4'd3, 0, 4'd3, 0, 1);
    step(0, 0, 4'd0, 1, 4'd2, 0, 1);
    step(0, 0, 4'd0, 0, 4'd2, 0, 1);
    step(0, 0, 4'd0, 1, 4'd1, 0, 1);
    step(0, 0, 4'd0, 0, 4'd1, 0, 1);
    step(0, 0, 4'd0, 1, 4'd0, 1, 0);
    step(0, 0, 4'd0, 0, 4'd0, 0, 0);

    // Load 9 with enable: no decrement in load cycle
    step(0, 1, 4'd9, 1, 4'd9, 0, 1);
    step(0, 0, 4'd0, 1, 4'd8, 0, 1);
    step(0, 0, 4'd0, 1, 4'd7, 0, 1);
    step(0, 0, 4'd0, 1, 4'd6, 0, 1);
    // Reload 2 mid-run at count 6
    step(0, 1, 4'd2, 1, 4'd2, 0, 1);
    step(0, 0, 4'd0, 1, 4'd1, 0, 1);
    step(0, 0, 4'd0, 1, 4'd0, 1, 0);
    // Load 0 -> IDLE, no pulse; enable ignored in IDLE
    step(0, 1, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 1, 4'd0, 0, 0);

    // Load accepted in the same cycle tc_pulse is high
    step(0, 1, 4'd1, 1, 4'd1, 0, 1);
    step(0, 0, 4'd0, 1, 4'd0, 1, 0);
    step(0, 1, 4'd4, 1, 4'd4, 0, 1);
    step(0, 0, 4'd0, 1, 4'd3, 0, 1);

    // Load 15, reset at count 8
    step(0, 1, 4'd15, 1, 4'd15, 0, 1);
    for (int i = 14; i >= 8; i--) step(0, 0, 4'd0, 1, 4'(i), 0, 1);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 1, 4'd0, 0, 0);

    // Reset while the pulse is about to fire suppresses it
    step(0, 1, 4'd1, 0, 4'd1, 0, 1);
    step(1, 0, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 1, 4'd0, 0, 0);
`else
    // Auto-reload: load 3, 12 enabled cycles -> 4 periodic pulses
    step(0, 1, 4'd3, 1, 4'd3, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'd0, 1, 4'd2, 0, 1);
      step(0, 0, 4'd0, 1, 4'd1, 0, 1);
      step(0, 0, 4'd0, 1, 4'd3, 1, 1);
    end
    step(0, 0, 4'd0, 0, 4'd3, 0, 1);
    step(0, 1, 4'd0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd0, 1, 4'd0, 0, 0);
`endif

    reset = 1'b0; load = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompare++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompare);
    $finish;
  end

endmodule : tb_down_counter_timer
